// File: rtl/sd_serial_emitter.sv
// Parallel-to-serial signed-digit emitter: Booth-recodes a two's-complement word into radix-2 SD digits, MSD first.
// Optional stall input io_hold is compiled in when SD_EMIT_HOLD_EN is defined.
module sd_serial_emitter #(
  parameter int WIDTH = 14,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_in,
  input  logic             io_load,
`ifdef SD_EMIT_HOLD_EN
  input  logic             io_hold,
`endif
  output logic             io_ready,
  output logic [1:0]       io_a,
  output logic             io_start,
  output logic             io_valid,
  output logic             io_last
);

  localparam logic IDLE = 1'b0;
  localparam logic EMIT = 1'b1;

  logic             state;
  logic [WIDTH:0]   sr;
  logic [CNT_W-1:0] cnt;
  logic             stall;
  logic             accept;

  // Digit for the bit pair (b_(i-1), b_i): +1 -> 2'b10, -1 -> 2'b01, else 0.
  function automatic logic [1:0] sd_digit(input logic lo, input logic hi);
    logic [1:0] d;
    case ({hi, lo})
      2'b01:   d = 2'b10;
      2'b10:   d = 2'b01;
      default: d = 2'b00;
    endcase
    return d;
  endfunction

`ifdef SD_EMIT_HOLD_EN
  assign stall = (state == EMIT) & io_hold;
`else
  assign stall = 1'b0;
`endif

  assign io_ready = (state == IDLE) | (io_last & ~stall);
  assign accept   = io_load & io_ready;

  // The MSD is registered straight from io_in, so sr is stored already shifted by one:
  // its top two bits always hold the pair for the next digit to emit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      io_a     <= 2'b00;
      io_start <= 1'b0;
      io_valid <= 1'b0;
      io_last  <= 1'b0;
    end else if (!stall) begin
      if (accept) begin
        state    <= EMIT;
        sr       <= {io_in[WIDTH-2:0], 2'b00};
        cnt      <= CNT_W'(WIDTH - 1);
        io_a     <= sd_digit(io_in[WIDTH-2], io_in[WIDTH-1]);
        io_start <= 1'b1;
        io_valid <= 1'b1;
        io_last  <= 1'b0;
      end else if (state == EMIT) begin
        if (cnt == '0) begin
          state    <= IDLE;
          io_a     <= 2'b00;
          io_start <= 1'b0;
          io_valid <= 1'b0;
          io_last  <= 1'b0;
        end else begin
          sr       <= {sr[WIDTH-1:0], 1'b0};
          cnt      <= cnt - 1'b1;
          io_a     <= sd_digit(sr[WIDTH-1], sr[WIDTH]);
          io_start <= 1'b0;
          io_last  <= (cnt == CNT_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_serial_emitter.sv
// Directed bench for sd_serial_emitter (WIDTH = 14) with hand-computed digit sequences, MSD in the top bits.
module tb_sd_serial_emitter;
  localparam int W = 14;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] io_in;
  logic         io_load;
  logic         io_ready;
  logic [1:0]   io_a;
  logic         io_start;
  logic         io_valid;
  logic         io_last;
`ifdef SD_EMIT_HOLD_EN
  logic         io_hold;
`endif

  int tests = 0;
  int fails = 0;

  sd_serial_emitter #(.WIDTH(W), .CNT_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .io_in    (io_in),
    .io_load  (io_load),
`ifdef SD_EMIT_HOLD_EN
    .io_hold  (io_hold),
`endif
    .io_ready (io_ready),
    .io_a     (io_a),
    .io_start (io_start),
    .io_valid (io_valid),
    .io_last  (io_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string name);
    check({name, " valid"}, 32'(io_valid), 32'd0);
    check({name, " a"},     32'(io_a),     32'd0);
    check({name, " ready"}, 32'(io_ready), 32'd1);
    check({name, " start"}, 32'(io_start), 32'd0);
    check({name, " last"},  32'(io_last),  32'd0);
  endtask

  task automatic load_word(input logic [W-1:0] w);
    io_in   = w;
    io_load = 1'b1;
    tick;
    io_load = 1'b0;
  endtask

  // Called with the MSD of w already on the outputs.
  task automatic run_word(input string name, input logic [W-1:0] w, input logic [2*W-1:0] exp,
                          input bit chain, input logic [W-1:0] next_w, input bit poke, input bit hold_test);
    int sum = 0;
    for (int k = 0; k < W; k++) begin
      check($sformatf("%s d%0d a", name, k + 1),     32'(io_a),     32'(exp[2*(W-1-k) +: 2]));
      check($sformatf("%s d%0d valid", name, k + 1), 32'(io_valid), 32'd1);
      check($sformatf("%s d%0d start", name, k + 1), 32'(io_start), 32'(k == 0));
      check($sformatf("%s d%0d last", name, k + 1),  32'(io_last),  32'(k == W - 1));
      check($sformatf("%s d%0d ready", name, k + 1), 32'(io_ready), 32'(k == W - 1));
      if (io_a == 2'b10) sum += (1 << (W - 1 - k));
      else if (io_a == 2'b01) sum -= (1 << (W - 1 - k));
`ifdef SD_EMIT_HOLD_EN
      if (hold_test && k == 3) begin
        io_hold = 1'b1;
        repeat (3) begin
          tick;
          check($sformatf("%s hold a", name),     32'(io_a),     32'(exp[2*(W-1-k) +: 2]));
          check($sformatf("%s hold valid", name), 32'(io_valid), 32'd1);
          check($sformatf("%s hold ready", name), 32'(io_ready), 32'd0);
        end
        io_hold = 1'b0;
      end
`else
      if (hold_test && k == 3) check($sformatf("%s d4 busy", name), 32'(io_ready), 32'd0);
`endif
      if (poke && k == 4) begin
        io_in   = 14'h3FFF;
        io_load = 1'b1;
      end
      if (chain && k == W - 1) begin
        io_in   = next_w;
        io_load = 1'b1;
      end
      tick;
      io_load = 1'b0;
    end
    check({name, " sum"}, 32'(sum), 32'(int'($signed(w))));
  endtask

  initial begin
`ifdef SD_EMIT_HOLD_EN
    io_hold = 1'b0;
`endif
    reset   = 1'b1;
    io_load = 1'b0;
    io_in   = '0;
    repeat (3) tick;
    idle_chk("rst");
    reset = 1'b0;
    repeat (2) begin
      tick;
      idle_chk("idle");
    end

    load_word(14'h0000);
    run_word("w0000", 14'h0000, 28'h0000000, 1'b0, '0, 1'b0, 1'b0);
    idle_chk("after0000");

    load_word(14'h0001);
    run_word("w0001", 14'h0001, 28'h0000009, 1'b0, '0, 1'b0, 1'b0);
    idle_chk("after0001");

    load_word(14'h3FFF);
    run_word("w3fff", 14'h3FFF, 28'h0000001, 1'b0, '0, 1'b0, 1'b0);
    load_word(14'h2000);
    run_word("w2000", 14'h2000, 28'h4000000, 1'b0, '0, 1'b0, 1'b0);
    idle_chk("after2000");

    load_word(14'h1555);
    run_word("w1555", 14'h1555, 28'h9999999, 1'b1, 14'h0ABC, 1'b1, 1'b0);
    run_word("w0abc", 14'h0ABC, 28'h2666010, 1'b0, '0, 1'b0, 1'b0);
    idle_chk("after0abc");

    load_word(14'h1234);
    for (int k = 0; k < 7; k++) begin
      check($sformatf("abort d%0d a", k + 1), 32'(io_a), 32'(28'h9242190 >> (2 * (W - 1 - k)) & 28'h3));
      if (k == 6) reset = 1'b1;
      tick;
    end
    reset = 1'b0;
    idle_chk("aborted");
    tick;
    idle_chk("aborted2");

    reset   = 1'b1;
    io_in   = 14'h1234;
    io_load = 1'b1;
    tick;
    reset   = 1'b0;
    io_load = 1'b0;
    idle_chk("rst_over_load");

    load_word(14'h1234);
    run_word("w1234", 14'h1234, 28'h9242190, 1'b0, '0, 1'b0, 1'b1);
    idle_chk("after1234");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
